// File: rtl/hazard_pkg.sv
// Shared types and instruction-field constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        RUN         = 1'b0,
        MULDIV_BUSY = 1'b1
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

endpackage

// File: rtl/hazard_control_unit_load_use_detect.sv
// Load-use detector: flags an ID instruction that reads the register a load in ID/EX is about to write.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [31:0] instruction_id,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rt,
    output logic        lu
);

    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       reads_rt;

    assign opcode = instruction_id[OP_MSB:OP_LSB];
    assign rs     = instruction_id[RS_MSB:RS_LSB];
    assign rt     = instruction_id[RT_MSB:RT_LSB];

    // Only these formats use rt as a source; for I-type ALU ops and loads it is the destination.
    assign reads_rt = (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                      (opcode == OP_BNE)   || (opcode == OP_SW);

    assign lu = idex_memread && (idex_rt != 5'd0) &&
                ((idex_rt == rs) || (reads_rt && (idex_rt == rt)));

endmodule

// File: rtl/hazard_control_unit.sv
// Front-end hazard controller: load-use stalls, mult/div occupancy holds, taken-branch redirects.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int MUL_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instruction_ID,
    input  logic        MulDiv_ID,
    input  logic        IDEX_MemRead,
    input  logic [4:0]  IDEX_Rt,
    input  logic        Branch_Taken_EX,
    input  logic [31:0] Branch_Target_EX,
    output logic        PCWrite,
    output logic        freeze,
    output logic        flush,
    output logic        PCSrc,
    output logic [31:0] Branch_Address,
    output logic        IDEX_Bubble,
    output logic [31:0] Stall_Count
);

    localparam logic [3:0] BUSY_INIT = 4'(MUL_LATENCY - 1);

    state_e      state_q, state_d;
    logic [3:0]  busy_cnt_q, busy_cnt_d;
    logic [31:0] stall_count_q, stall_count_d;
    logic        lu;

    load_use_detect u_lu (
        .instruction_id (Instruction_ID),
        .idex_memread   (IDEX_MemRead),
        .idex_rt        (IDEX_Rt),
        .lu             (lu)
    );

    always_comb begin
        state_d        = state_q;
        busy_cnt_d     = busy_cnt_q;
        PCWrite        = 1'b1;
        freeze         = 1'b0;
        flush          = 1'b0;
        PCSrc          = 1'b0;
        Branch_Address = 32'd0;
        IDEX_Bubble    = 1'b0;

        if (rst) begin
            state_d    = RUN;
            busy_cnt_d = 4'd0;
        end else if (Branch_Taken_EX) begin
            // Anything in IF/ID is wrong-path, including a mult/div waiting to issue.
            PCSrc          = 1'b1;
            Branch_Address = Branch_Target_EX;
            flush          = 1'b1;
            IDEX_Bubble    = 1'b1;
            state_d        = RUN;
            busy_cnt_d     = 4'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (lu) begin
                        PCWrite     = 1'b0;
                        freeze      = 1'b1;
                        IDEX_Bubble = 1'b1;
                    end else if (MulDiv_ID) begin
                        state_d    = MULDIV_BUSY;
                        busy_cnt_d = BUSY_INIT;
                    end
                end
                MULDIV_BUSY: begin
                    PCWrite     = 1'b0;
                    freeze      = 1'b1;
                    IDEX_Bubble = 1'b1;
                    busy_cnt_d  = busy_cnt_q - 4'd1;
                    if (busy_cnt_q == 4'd1) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d    = RUN;
                    busy_cnt_d = 4'd0;
                end
            endcase
        end

        // freeze is already low during reset, so this never counts reset cycles.
        stall_count_d = stall_count_q;
        if (freeze && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            busy_cnt_q    <= 4'd0;
            stall_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            busy_cnt_q    <= busy_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign Stall_Count = stall_count_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: single-cycle vector table plus multi-cycle sequences.
module tb_hazard_control_unit;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Instruction_ID;
    logic        MulDiv_ID;
    logic        IDEX_MemRead;
    logic [4:0]  IDEX_Rt;
    logic        Branch_Taken_EX;
    logic [31:0] Branch_Target_EX;
    logic        PCWrite, freeze, flush, PCSrc, IDEX_Bubble;
    logic [31:0] Branch_Address;
    logic [31:0] Stall_Count;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_stall;

    hazard_control_unit #(.MUL_LATENCY(LAT)) dut (
        .clk              (clk),
        .rst              (rst),
        .Instruction_ID   (Instruction_ID),
        .MulDiv_ID        (MulDiv_ID),
        .IDEX_MemRead     (IDEX_MemRead),
        .IDEX_Rt          (IDEX_Rt),
        .Branch_Taken_EX  (Branch_Taken_EX),
        .Branch_Target_EX (Branch_Target_EX),
        .PCWrite          (PCWrite),
        .freeze           (freeze),
        .flush            (flush),
        .PCSrc            (PCSrc),
        .Branch_Address   (Branch_Address),
        .IDEX_Bubble      (IDEX_Bubble),
        .Stall_Count      (Stall_Count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        muldiv;
        logic        memread;
        logic [4:0]  rt;
        logic        br;
        logic [31:0] target;
        logic        e_pcw, e_frz, e_fl, e_pcs, e_bub;
        logic [31:0] e_addr;
    } vec_t;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, 16'h0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic pcw, input logic frz, input logic fl,
                           input logic pcs, input logic bub, input logic [31:0] addr);
        chk({name, ".PCWrite"}, 32'(PCWrite), 32'(pcw));
        chk({name, ".freeze"}, 32'(freeze), 32'(frz));
        chk({name, ".flush"}, 32'(flush), 32'(fl));
        chk({name, ".PCSrc"}, 32'(PCSrc), 32'(pcs));
        chk({name, ".IDEX_Bubble"}, 32'(IDEX_Bubble), 32'(bub));
        chk({name, ".Branch_Address"}, Branch_Address, addr);
    endtask

    task automatic idle_inputs();
        Instruction_ID   = 32'd0;
        MulDiv_ID        = 1'b0;
        IDEX_MemRead     = 1'b0;
        IDEX_Rt          = 5'd0;
        Branch_Taken_EX  = 1'b0;
        Branch_Target_EX = 32'd0;
    endtask

    vec_t vecs[$];

    initial begin
        // name, instr, muldiv, memread, rt, br, target, pcw, frz, fl, pcs, bub, addr
        vecs.push_back('{"idle",        32'd0,                 0, 0, 5'd0, 0, 32'h0,  1, 0, 0, 0, 0, 32'h0});
        vecs.push_back('{"lu_rs",       mk(6'd0, 5'd8, 5'd2),  0, 1, 5'd8, 0, 32'h0,  0, 1, 0, 0, 1, 32'h0});
        vecs.push_back('{"after_lu",    mk(6'd0, 5'd8, 5'd2),  0, 0, 5'd8, 0, 32'h0,  1, 0, 0, 0, 0, 32'h0});
        vecs.push_back('{"lu_rt_rtype", mk(6'd0, 5'd2, 5'd8),  0, 1, 5'd8, 0, 32'h0,  0, 1, 0, 0, 1, 32'h0});
        vecs.push_back('{"rt_zero",     mk(6'd0, 5'd0, 5'd0),  0, 1, 5'd0, 0, 32'h0,  1, 0, 0, 0, 0, 32'h0});
        vecs.push_back('{"addi_rt",     mk(6'd8, 5'd0, 5'd8),  0, 1, 5'd8, 0, 32'h0,  1, 0, 0, 0, 0, 32'h0});
        vecs.push_back('{"sw_rt",       mk(6'd43, 5'd3, 5'd8), 0, 1, 5'd8, 0, 32'h0,  0, 1, 0, 0, 1, 32'h0});
        vecs.push_back('{"beq_rt",      mk(6'd4, 5'd3, 5'd8),  0, 1, 5'd8, 0, 32'h0,  0, 1, 0, 0, 1, 32'h0});
        vecs.push_back('{"bne_rt",      mk(6'd5, 5'd3, 5'd8),  0, 1, 5'd8, 0, 32'h0,  0, 1, 0, 0, 1, 32'h0});
        vecs.push_back('{"lw_rt",       mk(6'd35, 5'd3, 5'd8), 0, 1, 5'd8, 0, 32'h0,  1, 0, 0, 0, 0, 32'h0});
        vecs.push_back('{"no_memread",  mk(6'd0, 5'd8, 5'd8),  0, 0, 5'd8, 0, 32'h0,  1, 0, 0, 0, 0, 32'h0});
        vecs.push_back('{"lu_muldiv",   mk(6'd0, 5'd8, 5'd2),  1, 1, 5'd8, 0, 32'h0,  0, 1, 0, 0, 1, 32'h0});
        vecs.push_back('{"no_busy",     32'd0,                 0, 0, 5'd0, 0, 32'h0,  1, 0, 0, 0, 0, 32'h0});
        vecs.push_back('{"br_prio",     mk(6'd0, 5'd8, 5'd2),  1, 1, 5'd8, 1, 32'h40, 1, 0, 1, 1, 1, 32'h40});
        vecs.push_back('{"after_br",    32'd0,                 0, 0, 5'd0, 0, 32'h0,  1, 0, 0, 0, 0, 32'h0});

        idle_inputs();
        rst = 1'b1;
        Branch_Taken_EX  = 1'b1;
        Branch_Target_EX = 32'hDEAD_BEEF;
        MulDiv_ID        = 1'b1;
        repeat (2) @(negedge clk);
        #1 chk_out("reset", 1, 0, 0, 0, 0, 32'h0);
        chk("reset.Stall_Count", Stall_Count, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        exp_stall = 32'd0;

        // Table: each vector is applied for one cycle, starting from RUN.
        foreach (vecs[i]) begin
            Instruction_ID   = vecs[i].instr;
            MulDiv_ID        = vecs[i].muldiv;
            IDEX_MemRead     = vecs[i].memread;
            IDEX_Rt          = vecs[i].rt;
            Branch_Taken_EX  = vecs[i].br;
            Branch_Target_EX = vecs[i].target;
            #1;
            chk_out(vecs[i].name, vecs[i].e_pcw, vecs[i].e_frz, vecs[i].e_fl,
                    vecs[i].e_pcs, vecs[i].e_bub, vecs[i].e_addr);
            chk({vecs[i].name, ".Stall_Count"}, Stall_Count, exp_stall);
            if (vecs[i].e_frz) exp_stall = exp_stall + 32'd1;
            @(negedge clk);
        end
        idle_inputs();

        // Multicycle op: issue cycle, then exactly LAT-1 frozen cycles.
        MulDiv_ID = 1'b1;
        #1 chk_out("mul_issue", 1, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        MulDiv_ID = 1'b0;
        for (int c = 0; c < LAT - 1; c++) begin
            #1 chk_out($sformatf("mul_busy%0d", c), 0, 1, 0, 0, 1, 32'h0);
            chk($sformatf("mul_busy%0d.Stall_Count", c), Stall_Count, exp_stall);
            exp_stall = exp_stall + 32'd1;
            @(negedge clk);
        end
        #1 chk_out("mul_done", 1, 0, 0, 0, 0, 32'h0);
        chk("mul_done.Stall_Count", Stall_Count, exp_stall);
        @(negedge clk);

        // Redirect during a busy period abandons it.
        MulDiv_ID = 1'b1;
        @(negedge clk);
        MulDiv_ID = 1'b0;
        Branch_Taken_EX  = 1'b1;
        Branch_Target_EX = 32'h0000_1234;
        #1 chk_out("busy_redirect", 1, 0, 1, 1, 1, 32'h1234);
        @(negedge clk);
        idle_inputs();
        #1 chk_out("after_busy_redirect", 1, 0, 0, 0, 0, 32'h0);
        @(negedge clk);

        // Reset during the second busy cycle.
        MulDiv_ID = 1'b1;
        @(negedge clk);
        MulDiv_ID = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        Branch_Taken_EX  = 1'b1;
        Branch_Target_EX = 32'h0000_0080;
        #1 chk_out("rst_mid_busy", 1, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #1 chk_out("post_rst", 1, 0, 0, 0, 0, 32'h0);
        chk("post_rst.Stall_Count", Stall_Count, 32'd0);
        @(negedge clk);
        #1 chk("post_rst2.freeze", 32'(freeze), 32'd0);
        chk("post_rst2.Stall_Count", Stall_Count, 32'd0);

        // Saturation: preload the counter just below the top, then run a busy period.
        force dut.stall_count_q = 32'hFFFF_FFFE;
        #1 release dut.stall_count_q;
        chk("sat_preload", Stall_Count, 32'hFFFF_FFFE);
        MulDiv_ID = 1'b1;
        @(negedge clk);
        MulDiv_ID = 1'b0;
        exp_stall = 32'hFFFF_FFFE;
        for (int c = 0; c < LAT - 1; c++) begin
            #1 chk($sformatf("sat_busy%0d", c), Stall_Count, exp_stall);
            if (exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
            @(negedge clk);
        end
        #1 chk("sat_final", Stall_Count, 32'hFFFF_FFFF);
        @(negedge clk);
        #1 chk("sat_hold", Stall_Count, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
